// File: rtl/pm_fetch.sv
// Program-memory fetch unit: a PC drives pm_adr, fetched words land in a
// 2-entry queue, and a FETCH/HALT state machine gates fetching.
module pm_fetch #(
    parameter logic [4:0] RESET_ADR = 5'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] pm_adr,
    input  logic [5:0] pm_data,
    output logic [5:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       jump_en,
    input  logic [4:0] jump_adr,
    input  logic       halt,
    output logic       halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  mem0_q, mem0_d;
    logic [5:0]  mem1_q, mem1_d;
    logic        halted_q, halted_d;
    logic        pop;
    logic        push;

    // Handshake: a word transfers on an edge where instr_valid and instr_ready
    // are both high; instr holds steady while valid is high and ready is low.
    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = instr_valid ? mem0_q : 6'd0;
    assign pm_adr      = pc_q;
    assign halted      = halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        pop      = instr_valid && instr_ready;
        push     = 1'b0;

        if (jump_en) begin
            // Redirect flushes everything; the target word is fetched next edge.
            cnt_d   = 2'd0;
            pc_d    = jump_adr;
            state_d = FETCH;
        end else begin
            if (state_q == FETCH && halt) begin
                state_d = HALT;
            end
            push = (state_q == FETCH) && !halt && ((cnt_q != 2'd2) || pop);

            case ({pop, push})
                2'b10: begin
                    mem0_d = mem1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        mem0_d = pm_data;
                    end else begin
                        mem1_d = pm_data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        mem0_d = pm_data;
                    end else begin
                        mem0_d = mem1_q;
                        mem1_d = pm_data;
                    end
                end
                default: begin
                end
            endcase

            if (push) begin
                pc_d = pc_q + 5'd1;
            end
        end

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_ADR;
            cnt_q    <= 2'd0;
            mem0_q   <= 6'd0;
            mem1_q   <= 6'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: doc/pm_fetch.md
PM_FETCH -- requirements
Module: pm_fetch

Interface
REQ-001 SHALL have parameter RESET_ADR, default 5'd0, meaning the program address fetched first after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on reset assertion, independent of the clock.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pm_adr  output  5  program memory address; SHALL equal the PC register directly, with no combinational path from any input.
REQ-006 pm_data  input  6  program memory word; combinational, valid in the same cycle as pm_adr.
REQ-007 instr  output  6  instruction at the queue head.
REQ-008 instr_valid  output  1  high when the queue is non-empty.
REQ-009 instr_ready  input  1  consumer accepts instr this cycle.
REQ-010 jump_en  input  1  redirect request, sampled on the clock edge.
REQ-011 jump_adr  input  5  redirect target address.
REQ-012 halt  input  1  stop-fetch request, sampled on the clock edge.
REQ-013 halted  output  1  high while in state HALT.

Function
REQ-014 SHALL contain a 5-bit PC, a 2-entry FIFO of 6-bit words, and a state register with states FETCH and HALT.
REQ-015 Pop: SHALL occur when instr_valid and instr_ready are both high; the head is removed at the edge.
REQ-016 Push (FETCH only, no jump): at the edge, pm_data SHALL be written when the queue has fewer than 2 entries, or holds 2 entries and a pop occurs in the same cycle; PC SHALL then advance by 1.
REQ-017 When the queue is full and no pop occurs, PC and queue SHALL hold; pm_adr stays stable.
REQ-018 PC arithmetic SHALL be modulo 32; address 31 SHALL be followed by address 0.
REQ-019 Simultaneous pop and push on a 1-entry queue SHALL leave 1 entry, with the new word at the head.
REQ-020 When queue count is 0, instr SHALL be 6'd0.
REQ-021 instr SHALL remain stable while instr_valid is high and instr_ready is low.
REQ-022 jump_en SHALL have the highest priority: at the edge, queue flushed to empty, PC := jump_adr, state := FETCH, no push and no pop take effect.
REQ-023 A jump's first instruction SHALL appear with instr_valid high 2 edges after the jump edge: PC is loaded on the first edge, and the word is pushed on the second.
REQ-024 halt without jump_en in FETCH: at the edge, state := HALT, and no push occurs at that edge.
REQ-025 In HALT: no pushes and PC holds; pops continue so the queue drains normally.
REQ-026 Exit from HALT SHALL be only by jump_en (per REQ-022) or by reset; halt is ignored while in HALT.
REQ-027 jump_en and halt high together: jump SHALL win and the state SHALL be FETCH.
REQ-028 halted SHALL be a registered decode of state HALT.

Reset
REQ-029 On rst_n low: PC = RESET_ADR, queue count = 0, instr = 6'd0, instr_valid = 0, state = FETCH, halted = 0, pm_adr = RESET_ADR.
REQ-030 Reset asserted mid-operation SHALL discard queued words and any pending jump or halt.
REQ-031 After rst_n deasserts, the first push SHALL occur on the first rising edge, so instr_valid goes high after that edge.

Verification
REQ-032 Reset release, ROM[i] = i+1, instr_ready = 1 -> instr sequence 1,2,3,... at one per cycle; pm_adr 0,1,2,...
REQ-033 instr_ready = 0 for 5 cycles from reset -> queue holds ROM[0],ROM[1]; pm_adr holds at 2; instr = ROM[0] stable; releasing ready -> ROM[0],ROM[1],ROM[2] in order.
REQ-034 Continuous ready across address 31 -> instr ROM[30],ROM[31],ROM[0],ROM[1]; pm_adr 31 -> 0.
REQ-035 jump_en = 1 with jump_adr = 5'd20 while the queue is full -> next cycle instr_valid = 0 and pm_adr = 20; the following cycle instr = ROM[20] and instr_valid = 1.
REQ-036 halt pulse with 2 entries queued, ready = 1 -> halted = 1; exactly 2 more instructions delivered, then instr_valid = 0 and pm_adr frozen; jump_en to 5 -> halted = 0, then ROM[5] delivered.
REQ-037 rst_n pulsed low asynchronously mid-stream with queue full -> instr_valid = 0 and pm_adr = RESET_ADR immediately, before the next clock edge.
